// File: rtl/store_trace_monitor_pkg.sv
// Shared types and default constants for the store trace monitor.
// Holds the verdict state encoding and the packed trace entry layout.
package store_trace_pkg;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    PASSED  = 2'd1,
    FAILED  = 2'd2
  } verdict_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  localparam int          DEF_DEPTH       = 16;
  localparam logic [31:0] DEF_RESULT_ADDR = 32'd100;
  localparam logic [31:0] DEF_PASS_VALUE  = 32'd25;
  localparam logic [31:0] DEF_TIMEOUT     = 32'd100000;

endpackage

// File: rtl/store_trace_monitor_if.sv
// Store bus observed after the BSR mux plus the trace read channel.
// slave = the monitor; master = the bus source and the JTAG-side reader.
interface store_trace_monitor_if
  import store_trace_pkg::*;
();

  logic         mem_write;
  logic [31:0]  data_adr;
  logic [31:0]  write_data;
  logic         rd_valid;
  logic         rd_ready;
  trace_entry_t rd_data;

  modport slave (
    input  mem_write,
    input  data_adr,
    input  write_data,
    input  rd_ready,
    output rd_valid,
    output rd_data
  );

  modport master (
    output mem_write,
    output data_adr,
    output write_data,
    output rd_ready,
    input  rd_valid,
    input  rd_data
  );

endinterface

// File: rtl/store_trace_monitor_trace_fifo.sv
// First-word-fall-through synchronous FIFO; a push is visible at the head one edge later.
// Push is refused when full unless a pop happens on the same edge; pop on empty is ignored.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Masking the head while empty keeps stale storage off the output after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge sysclk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_trace_monitor.sv
// Traces core stores into a FIFO and latches a pass/fail verdict from the mailbox store; halt_req follows the verdict.
// Trace head valid one edge after the store; STORE_TRACE_WATCHDOG_EN adds a cycle-limit fail.
module store_trace_monitor
  import store_trace_pkg::*;
#(
  parameter int          DEPTH       = DEF_DEPTH,
  parameter logic [31:0] RESULT_ADDR = DEF_RESULT_ADDR,
  parameter logic [31:0] PASS_VALUE  = DEF_PASS_VALUE,
  parameter logic [31:0] TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                    sysclk,
  input  logic                    reset,
  store_trace_monitor_if.slave    bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    success,
  output logic                    fail,
  output logic                    halt_req
);

  localparam logic [1:0] S_MONITOR = MONITOR;
  localparam logic [1:0] S_PASSED  = PASSED;
  localparam logic [1:0] S_FAILED  = FAILED;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic         in_monitor;
  logic         adr_hit;
  logic         pass_hit;
  logic         push_req;
  logic         pop_fire;
  logic         fifo_empty;
  logic         fifo_full;
  logic         wd_expire;
  trace_entry_t wr_entry;

  assign in_monitor = (state == S_MONITOR);

  // Case equality so an X/Z bit can never match and therefore never yields a pass.
  assign adr_hit  = bus.mem_write && (bus.data_adr === RESULT_ADDR);
  assign pass_hit = adr_hit && (bus.write_data === PASS_VALUE);

  assign push_req = bus.mem_write && in_monitor;
  assign pop_fire = bus.rd_ready && !fifo_empty;

  assign wr_entry.addr = bus.data_adr;
  assign wr_entry.data = bus.write_data;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_entry_t))
  ) u_trace_fifo (
    .sysclk  (sysclk),
    .reset   (reset),
    .push    (push_req),
    .wr_data (wr_entry),
    .pop     (bus.rd_ready),
    .rd_data (bus.rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (count)
  );

  assign bus.rd_valid = !fifo_empty;

`ifdef STORE_TRACE_WATCHDOG_EN
  logic [31:0] wd_cnt;

  // Expires on the edge the counter would reach TIMEOUT; frozen once a verdict exists.
  assign wd_expire = in_monitor && (wd_cnt == TIMEOUT - 32'd1);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (in_monitor) begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign wd_expire      = 1'b0;
`endif

  // A mailbox store outranks a watchdog expiry on the same edge.
  always_comb begin
    state_nxt = state;
    if (in_monitor) begin
      if (adr_hit) begin
        state_nxt = pass_hit ? S_PASSED : S_FAILED;
      end else if (wd_expire) begin
        state_nxt = S_FAILED;
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state    <= S_MONITOR;
      success  <= 1'b0;
      fail     <= 1'b0;
      halt_req <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      success  <= (state_nxt == S_PASSED);
      fail     <= (state_nxt == S_FAILED);
      halt_req <= (state_nxt != S_MONITOR);
      if (push_req && fifo_full && !pop_fire) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_trace_monitor.sv
// Directed bench for store_trace_monitor: trace order, full/overflow, verdicts, stall and async reset.
// Watchdog vectors run only when STORE_TRACE_WATCHDOG_EN is defined.
module tb_store_trace_monitor;
  import store_trace_pkg::*;

  localparam int DEPTH = 16;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [4:0] count;
  logic       overflow;
  logic       success;
  logic       fail;
  logic       halt_req;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sysclk = ~sysclk;

  store_trace_monitor_if bus();

  store_trace_monitor #(
    .DEPTH       (DEPTH),
    .RESULT_ADDR (32'd100),
    .PASS_VALUE  (32'd25),
    .TIMEOUT     (32'd50)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .bus      (bus.slave),
    .count    (count),
    .overflow (overflow),
    .success  (success),
    .fail     (fail),
    .halt_req (halt_req)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.mem_write  = 1'b1;
    bus.data_adr   = a;
    bus.write_data = d;
    tick();
    bus.mem_write  = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.mem_write  = 1'b0;
    bus.data_adr   = '0;
    bus.write_data = '0;
    bus.rd_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rd_valid"}, 64'(bus.rd_valid), 64'd0);
    check({tag, ".rd_data"},  bus.rd_data,       64'd0);
    check({tag, ".count"},    64'(count),        64'd0);
    check({tag, ".overflow"}, 64'(overflow),     64'd0);
    check({tag, ".success"},  64'(success),      64'd0);
    check({tag, ".fail"},     64'(fail),         64'd0);
    check({tag, ".halt_req"}, 64'(halt_req),     64'd0);
  endtask

  logic [31:0] t3_addr [3];
  logic [31:0] t3_data [3];
  logic [63:0] held;

  initial begin
    t3_addr = '{32'h10, 32'h14, 32'h18};
    t3_data = '{32'hA,  32'hB,  32'hC};

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Three stores then drain; head valid right after the first store
    store(t3_addr[0], t3_data[0]);
    check("lat.rd_valid", 64'(bus.rd_valid), 64'd1);
    check("lat.rd_data",  bus.rd_data, 64'h00000010_0000000A);
    store(t3_addr[1], t3_data[1]);
    store(t3_addr[2], t3_data[2]);
    check("three.count", 64'(count), 64'd3);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("three.head%0d", i), bus.rd_data, {t3_addr[i], t3_data[i]});
      tick();
      check($sformatf("three.count%0d", i), 64'(count), 64'(2 - i));
    end
    check("three.rd_valid", 64'(bus.rd_valid), 64'd0);
    check("three.overflow", 64'(overflow), 64'd0);
    tick();
    check("empty_pop.count", 64'(count), 64'd0);
    bus.rd_ready = 1'b0;

    // 17 stores, no drain: last one dropped
    do_reset();
    for (int i = 0; i < DEPTH; i++) store(32'h200 + 32'(4 * i), 32'(i));
    check("full.count16", 64'(count), 64'd16);
    check("full.ovf_before", 64'(overflow), 64'd0);
    store(32'h300, 32'hDEAD);
    check("full.count17", 64'(count), 64'd16);
    check("full.overflow", 64'(overflow), 64'd1);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("full.head%0d", i), bus.rd_data, {32'h200 + 32'(4 * i), 32'(i)});
      tick();
    end
    check("full.no17", 64'(bus.rd_valid), 64'd0);
    bus.rd_ready = 1'b0;

    // 17 stores with a pop on the 17th edge
    do_reset();
    for (int i = 0; i < DEPTH; i++) store(32'h200 + 32'(4 * i), 32'(i));
    bus.rd_ready = 1'b1;
    store(32'h300, 32'hBEEF);
    bus.rd_ready = 1'b0;
    check("fullpop.count", 64'(count), 64'd16);
    check("fullpop.overflow", 64'(overflow), 64'd0);
    check("fullpop.head", bus.rd_data, {32'h204, 32'd1});
    bus.rd_ready = 1'b1;
    repeat (DEPTH - 1) tick();
    check("fullpop.last", bus.rd_data, {32'h300, 32'hBEEF});
    tick();
    bus.rd_ready = 1'b0;

    // Pass verdict; later mailbox store ignored; drain still works
    do_reset();
    store(32'd100, 32'd25);
    check("pass.success", 64'(success), 64'd1);
    check("pass.fail", 64'(fail), 64'd0);
    check("pass.halt", 64'(halt_req), 64'd1);
    check("pass.count", 64'(count), 64'd1);
    store(32'd100, 32'd7);
    check("pass.later_fail", 64'(fail), 64'd0);
    check("pass.later_success", 64'(success), 64'd1);
    check("pass.later_count", 64'(count), 64'd1);
    check("pass.head", bus.rd_data, {32'd100, 32'd25});
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("pass.drain", 64'(count), 64'd0);

    // Fail verdict
    do_reset();
    store(32'd100, 32'd24);
    check("failv.fail", 64'(fail), 64'd1);
    check("failv.success", 64'(success), 64'd0);
    check("failv.halt", 64'(halt_req), 64'd1);

    // Non-mailbox store leaves verdict idle
    do_reset();
    store(32'd104, 32'd25);
    check("nomail.success", 64'(success), 64'd0);
    check("nomail.halt", 64'(halt_req), 64'd0);

    // Stall with two entries, then async reset mid-drain
    do_reset();
    store(32'h40, 32'h1);
    store(32'h44, 32'h2);
    held = {32'h40, 32'h1};
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall.data%0d", i), bus.rd_data, held);
    end
    check("stall.count", 64'(count), 64'd2);
    bus.rd_ready = 1'b1;
    tick();
    check("stall.popped", bus.rd_data, {32'h44, 32'h2});
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_rst.count", 64'(count), 64'd0);
    check("post_rst.valid", 64'(bus.rd_valid), 64'd0);
    bus.rd_ready = 1'b0;

`ifdef STORE_TRACE_WATCHDOG_EN
    // Watchdog expiry with no mailbox store
    do_reset();
    repeat (49) tick();
    check("wd.fail49", 64'(fail), 64'd0);
    tick();
    check("wd.fail50", 64'(fail), 64'd1);
    check("wd.halt50", 64'(halt_req), 64'd1);
    check("wd.success50", 64'(success), 64'd0);

    // Mailbox pass on the expiry edge wins
    do_reset();
    repeat (49) tick();
    store(32'd100, 32'd25);
    check("wd_race.success", 64'(success), 64'd1);
    check("wd_race.fail", 64'(fail), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_trace_monitor.md
Name: store_trace_monitor

Overview:
- Sits directly downstream of the boundary-scan-muxed data-memory bus (MemWriteM/DataAdrM/WriteDataM after the BSR).
- Captures every core store into a trace FIFO, and decides the self-test verdict (pass/fail) at a mailbox address.
- Raises a halt request to the debug clock controller once a verdict is reached.
- A JTAG-side data-register reader drains the trace through a valid/ready handshake.

Parameters:
- DEPTH, 16, trace FIFO entries; power of two, at least 2.
- RESULT_ADDR, 32'd100, mailbox address checked for the verdict.
- PASS_VALUE, 32'd25, store data at RESULT_ADDR that means pass.
- TIMEOUT, 32'd100000, watchdog cycle limit; used only with WATCHDOG_EN.

Ports:
- sysclk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; the OR of sys_reset and dm_reset.
- mem_write, input, 1, store strobe; one store per high cycle.
- data_adr, input, 32, store address.
- write_data, input, 32, store data.
- rd_ready, input, 1, reader accepts the head entry.
- rd_valid, output, 1, FIFO head is valid.
- rd_data, output, 64, head entry: {addr[31:0], data[31:0]}.
- count, output, $clog2(DEPTH)+1, current FIFO occupancy.
- overflow, output, 1, sticky; at least one store was dropped.
- success, output, 1, sticky pass verdict.
- fail, output, 1, sticky fail verdict.
- halt_req, output, 1, request to gate the core clock.

Behaviour:
- Reset (asynchronous): FIFO empty, pointers 0, state MONITOR.
  - rd_valid, count, overflow, success, fail and halt_req all 0.
  - rd_data is 0 (head register cleared).
- Push: on a sysclk edge with mem_write=1 and state MONITOR, write {data_adr, write_data}.
  - Every store is captured, including the mailbox store.
- Pop: an entry is consumed on an edge where rd_valid=1 and rd_ready=1.
- rd_data is first-word-fall-through.
  - rd_valid=1 whenever count>0.
  - rd_data always shows the oldest entry; it must not change while rd_valid=1 and rd_ready=0.
- Push latency: a store at edge N gives rd_valid=1 after edge N when the FIFO was empty. No combinational path from mem_write to rd_valid.
- Full, push, no pop: the store is dropped. overflow is set at that edge and count stays at DEPTH.
- Full, push and pop on the same edge: both happen, count stays at DEPTH, overflow is not set.
- Empty, rd_ready=1: no effect, and count does not underflow.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is the separate occupancy register with one extra bit.
- Verdict FSM states: MONITOR, PASSED, FAILED.
  - MONITOR to PASSED: mem_write && data_adr==RESULT_ADDR && write_data==PASS_VALUE. Set success.
  - MONITOR to FAILED: mem_write && data_adr==RESULT_ADDR && write_data!=PASS_VALUE. Set fail.
  - PASSED and FAILED are terminal until reset.
  - In PASSED/FAILED, halt_req=1 (registered, asserted from the edge that reaches the state).
  - In PASSED/FAILED, further stores are ignored: no push, no verdict change.
  - Draining still works in PASSED/FAILED.
- Comparisons are full 32-bit equality. Any bit that is X or Z is treated as a mismatch, so it cannot produce pass.
- success and fail are never both 1.
- Reset during a drain or mid-FIFO: everything clears immediately. A pending rd_ready is ignored until reset is released.

Optional Feature:
- Macro: STORE_TRACE_WATCHDOG_EN.
- Defined:
  - A 32-bit cycle counter counts while in MONITOR.
  - On the edge it reaches TIMEOUT with no verdict, go to FAILED, set fail and assert halt_req.
  - A mailbox store on the same edge has priority over the timeout.
  - The counter freezes outside MONITOR.
- Not defined: no counter exists, and MONITOR is left only by a mailbox store.

Decomposition:
- Package store_trace_pkg holds:
  - enum verdict_state_t {MONITOR, PASSED, FAILED};
  - typedef trace_entry_t, a packed struct {addr[31:0], data[31:0]};
  - the default RESULT_ADDR/PASS_VALUE constants.
- One sub-module, trace_fifo: a parameterised FWFT synchronous FIFO that owns push, pop, count, full and empty.
- The top level holds the verdict FSM, drop/overflow logic and the watchdog.

Test Plan:
- Three stores (0x10/0xA, 0x14/0xB, 0x18/0xC), then drain with rd_ready=1.
  - rd_data sequence 0x00000010_0000000A, 0x00000014_0000000B, 0x00000018_0000000C; count 3 to 0; overflow=0.
- 17 stores with DEPTH=16 and no drain: count=16 and overflow=1; entry 17 absent.
- Repeat with a pop on the 17th edge: count stays 16 and overflow=0.
- Store 100/25: success=1 and halt_req=1 on the next cycle.
  - A later store 100/7 leaves fail=0 and count unchanged.
- Store 100/24: fail=1, success=0, halt_req=1.
- Hold rd_ready=0 with 2 entries for 5 cycles: rd_data stable.
  - Assert reset mid-drain: all outputs 0 within the same cycle (asynchronous).
- With STORE_TRACE_WATCHDOG_EN and TIMEOUT=50:
  - No mailbox store gives fail=1 at cycle 50.
  - A store of 100/25 exactly at cycle 50 gives success=1.
